// File: rtl/fw_pkg.sv
// Shared definitions for the Floyd-Warshall kernel blocks.
//   FW_L     : default words per beat
//   FW_WIDTH : default bits per distance word
//   cnt_w()  : width of a counter that spans 0..n-1 (at least 1 bit)
package fw_pkg;

  localparam int unsigned FW_L     = 8;
  localparam int unsigned FW_WIDTH = 8;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fw_drain_fifo.sv
// First-word-fall-through FIFO used by the Floyd-Warshall result drain.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   push, wdata : write strobe and entry; caller never pushes when full
//                 unless it also pops in the same cycle
//   pop         : read strobe; caller never pops when empty
//   rdata       : head entry, zero when empty
//   level       : occupancy, 0..DEPTH
//   full, empty : derived from level
module fw_drain_fifo #(
  parameter int unsigned DW    = 65,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_comb begin
    full  = (cnt == LW'(DEPTH));
    empty = (cnt == '0);
    rdata = empty ? '0 : mem[rptr];
    level = cnt;
  end

endmodule

// File: rtl/fw_result_drain.sv
// Receive end of the Floyd-Warshall kernel output stream. Buffers one beat
// per cycle from the last PE in a FWFT FIFO and re-emits it over a
// valid/ready handshake, tagging every ROWS-th kernel beat as tile last.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   inD, in_valid       : kernel beat, no backpressure
//   outD, out_valid     : FIFO head (0 when empty), FIFO non-empty
//   out_ready           : sink accepts
//   out_last            : head beat closes its tile
//   tile_done           : one-cycle pulse after a tile's last beat transfers
//   level               : FIFO occupancy
//   overflow, ovf_clr   : sticky drop flag and its synchronous clear
//   err_cnt             : saturating dropped-beat count
// Build option: define FW_DRAIN_ERRCNT_EN to add the err_cnt port/counter.
module fw_result_drain
  import fw_pkg::*;
#(
  parameter int unsigned L     = FW_L,
  parameter int unsigned WIDTH = FW_WIDTH,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ROWS  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [L*WIDTH-1:0]      inD,
  input  logic                    in_valid,
  output logic [L*WIDTH-1:0]      outD,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    tile_done,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  input  logic                    ovf_clr
`ifdef FW_DRAIN_ERRCNT_EN
  ,
  output logic [15:0]             err_cnt
`endif
);

  localparam int unsigned DW = L * WIDTH;
  localparam int unsigned RW = cnt_w(ROWS);

  logic [RW-1:0] row_cnt;
  logic          row_last;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic [DW:0]   head;

  always_comb begin
    row_last  = (row_cnt == RW'(ROWS - 1));
    pop       = !empty && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push      = in_valid && (!full || pop);
    drop      = in_valid && full && !pop;
    out_valid = !empty;
    outD      = head[DW-1:0];
    out_last  = head[DW];
  end

  fw_drain_fifo #(
    .DW    (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({row_last, inD}),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Counts every kernel beat, dropped or not, so framing follows the kernel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt <= '0;
    end else if (in_valid) begin
      row_cnt <= row_last ? '0 : row_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tile_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      tile_done <= pop && head[DW];
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef FW_DRAIN_ERRCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (drop) begin
      if (ovf_clr)                err_cnt <= 16'd1;
      else if (err_cnt != '1)     err_cnt <= err_cnt + 1'b1;
    end else if (ovf_clr) begin
      err_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fw_result_drain.sv
// Directed bench for fw_result_drain with default parameters
// (L=8, WIDTH=8, DEPTH=16, ROWS=8). Honours FW_DRAIN_ERRCNT_EN.
module tb_fw_result_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] inD;
  logic        in_valid;
  logic [63:0] outD;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        tile_done;
  logic [4:0]  level;
  logic        overflow;
  logic        ovf_clr;
`ifdef FW_DRAIN_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fw_result_drain #(
    .L     (8),
    .WIDTH (8),
    .DEPTH (16),
    .ROWS  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inD       (inD),
    .in_valid  (in_valid),
    .outD      (outD),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .tile_done (tile_done),
    .level     (level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
`ifdef FW_DRAIN_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  typedef struct {
    logic iv;
    int   d;
    logic rdy;
    logic ev;
    int   ed;
    logic el;
    int   elvl;
    logic etd;
  } vec_t;

  vec_t tbl[10];

  // Transfer monitor: {last, data} of each accepted beat.
  logic [64:0] mon_q[$];
  logic [64:0] exp_q[$];
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) mon_q.push_back({out_last, outD});
  end

  function automatic logic [63:0] mk(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {8{b}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    inD = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic fill(input int base, input int n);
    out_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      inD = mk(base + k);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_seq(input string nm);
    chk({nm, "_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      chk($sformatf("%s_beat%0d_data", nm, i), mon_q[i][63:0], exp_q[i][63:0]);
      chk($sformatf("%s_beat%0d_last", nm, i), 64'(mon_q[i][64]), 64'(exp_q[i][64]));
    end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    inD = '0;
    step();
    step();
    chk("rst_outD", outD, 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_tile_done", 64'(tile_done), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
`ifdef FW_DRAIN_ERRCNT_EN
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    reset = 1'b1;

    // Single tile, sink always ready.
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, i, 1'b1, 1'b1, i, (i == 7), 1, 1'b0};
    tbl[8] = '{1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1};
    tbl[9] = '{1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].iv;
      inD       = mk(tbl[i].d);
      out_ready = tbl[i].rdy;
      step();
      chk($sformatf("t1_v%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      chk($sformatf("t1_v%0d_data", i), outD, tbl[i].ev ? mk(tbl[i].ed) : 64'd0);
      chk($sformatf("t1_v%0d_last", i), 64'(out_last), 64'(tbl[i].el));
      chk($sformatf("t1_v%0d_level", i), 64'(level), 64'(tbl[i].elvl));
      chk($sformatf("t1_v%0d_tile_done", i), 64'(tile_done), 64'(tbl[i].etd));
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Fill then drain.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      inD = mk(k);
      step();
      chk($sformatf("fill_level%0d", k), 64'(level), 64'(k + 1));
      chk($sformatf("fill_valid%0d", k), 64'(out_valid), 64'd1);
    end
    chk("fill_overflow", 64'(overflow), 64'd0);
    inD = mk(16);
    step();
    in_valid = 1'b0;
    chk("drop_overflow", 64'(overflow), 64'd1);
    chk("drop_level", 64'(level), 64'd16);
`ifdef FW_DRAIN_ERRCNT_EN
    chk("drop_err_cnt", 64'(err_cnt), 64'd1);
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain_data%0d", k), outD, mk(k));
      chk($sformatf("drain_last%0d", k), 64'(out_last), 64'((k % 8) == 7));
      step();
      chk($sformatf("drain_tile_done%0d", k), 64'(tile_done), 64'((k % 8) == 7));
    end
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr_overflow", 64'(overflow), 64'd0);
`ifdef FW_DRAIN_ERRCNT_EN
    chk("clr_err_cnt", 64'(err_cnt), 64'd0);
`endif

    // Simultaneous push and pop at full.
    do_reset();
    fill(0, 16);
    in_valid = 1'b1;
    inD = mk(16);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fullpp_level", 64'(level), 64'd16);
    chk("fullpp_overflow", 64'(overflow), 64'd0);
    chk("fullpp_head", outD, mk(1));
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("fullpp_data%0d", k), outD, mk(k + 1));
      chk($sformatf("fullpp_last%0d", k), 64'(out_last), 64'(((k + 1) % 8) == 7));
      step();
    end
    chk("fullpp_end_level", 64'(level), 64'd0);
    out_ready = 1'b0;

    // Framing through a drop: kernel beat 3 of the second-tile stream is lost.
    do_reset();
    mon_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    fill(100, 16);
    for (int r = 0; r < 8; r++) begin
      out_ready = (r != 3);
      in_valid = 1'b1;
      inD = mk(r);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) step();
    mon_en = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) exp_q.push_back({((k % 8) == 7), mk(100 + k)});
    for (int r = 0; r < 8; r++) if (r != 3) exp_q.push_back({(r == 7), mk(r)});
    chk_seq("frame");
    chk("frame_overflow", 64'(overflow), 64'd1);
    chk("frame_level", 64'(level), 64'd0);

    // Reset mid-stream.
    do_reset();
    fill(50, 5);
    chk("mid_level", 64'(level), 64'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_outD", outD, 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_last", 64'(out_last), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    step();
    reset = 1'b1;
    mon_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    fill(60, 8);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    mon_en = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), mk(60 + k)});
    chk_seq("post_rst");

    // Clear racing a drop.
    do_reset();
    fill(0, 16);
    in_valid = 1'b1;
    inD = mk(99);
    step();
    step();
    chk("race_pre_overflow", 64'(overflow), 64'd1);
`ifdef FW_DRAIN_ERRCNT_EN
    chk("race_pre_err_cnt", 64'(err_cnt), 64'd2);
`endif
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    in_valid = 1'b0;
    chk("race_overflow", 64'(overflow), 64'd1);
    chk("race_level", 64'(level), 64'd16);
`ifdef FW_DRAIN_ERRCNT_EN
    chk("race_err_cnt", 64'(err_cnt), 64'd1);
`endif
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("race_clr_overflow", 64'(overflow), 64'd0);
`ifdef FW_DRAIN_ERRCNT_EN
    chk("race_clr_err_cnt", 64'(err_cnt), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fw_result_drain.md
# fw_result_drain

Receive end of the Floyd-Warshall kernel output stream. Accepts one row-segment beat per cycle from the last PE (`L` words of `WIDTH` bits, qualified by a valid with no backpressure) and buffers it in a first-word-fall-through FIFO. Re-emits each beat to the host/memory side over a valid/ready handshake, framing every `ROWS` beats as one tile. Sits directly after the `fw` top-level, between the PE chain output and the write-back path.

## Interface
- `L`, 8, words per beat (same as kernel)
- `WIDTH`, 8, bits per distance word
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `ROWS`, 8, beats per tile; ≥ 1
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `inD`  in  `L*WIDTH`  beat from kernel `outD`
- `in_valid`  in  1  kernel `out_valid`; a beat is presented every cycle it is high
- `outD`  out  `L*WIDTH`  FIFO head; 0 when empty
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  sink accepts; transfer = `out_valid & out_ready`
- `out_last`  out  1  head beat is the final beat of its tile
- `tile_done`  out  1  one-cycle pulse after the last beat of a tile transfers
- `level`  out  `$clog2(DEPTH)+1`  current occupancy
- `overflow`  out  1  sticky: a beat was dropped
- `ovf_clr`  in  1  synchronous clear of `overflow` (and `err_cnt`)
- `err_cnt`  out  16  dropped-beat count; present only with `FW_DRAIN_ERRCNT_EN`

## Operation
- Entry = {last flag, data}; last flag = (write-side row counter == `ROWS-1`).
- Write-side row counter counts 0..`ROWS-1` and wraps; advances on every `in_valid` beat, including dropped beats, so tile framing stays aligned with the kernel.
- Push when `in_valid` and (not full, or full with a pop in the same cycle). Full with `in_valid` and no pop: beat dropped, `overflow` set, FIFO unchanged.
- Pop on `out_valid & out_ready`. `out_ready` while empty has no effect.
- Simultaneous push and pop: `level` unchanged, both pointers advance.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Full/empty is taken from `level`.
- `tile_done` registers `pop & out_last`.
- `ovf_clr` clears `overflow`. If `ovf_clr` and a drop occur in the same cycle, the set wins.
- Assertion of `reset` mid-stream discards buffered contents and zeroes the row counter. The first `in_valid` after release is row 0.

## Timing
- Reset values: `outD`=0, `out_valid`=0, `out_last`=0, `tile_done`=0, `level`=0, `overflow`=0, `err_cnt`=0.
- Latency: a beat pushed at edge t is visible on `outD`/`out_valid` after edge t (same cycle as `level` update). Minimum in-to-out is 1 cycle.
- Throughput: 1 beat/cycle sustained while `out_ready` is held high. No combinational path from `in_valid` or `out_ready` to any output.
- `out_last` is combinational from the head entry's flag.

## Configuration
- `FW_DRAIN_ERRCNT_EN` defined: `err_cnt` port exists. It increments on each dropped beat, saturates at 16'hFFFF, and is cleared by `ovf_clr`. A drop coinciding with `ovf_clr` leaves the count at 1.
- `FW_DRAIN_ERRCNT_EN` undefined: no port, no counter. `overflow` behaviour is identical.

## Structure
- Shared `fw_pkg`: default `L`, `WIDTH`, and a counter-width helper constant/function reused by other FW blocks.
- One sub-module, `fw_drain_fifo`: parameterised FWFT storage with push/pop/level/full/empty.
- The top level holds the row counter, drop/overflow logic, `tile_done`, and the optional error counter.

## Test plan
- **Single tile, sink always ready.** `ROWS`=8 beats, data 0..7, back-to-back → `out_valid` 1 cycle after each push. `out_last` on beat 7, `tile_done` pulse 1 cycle after beat 7 transfers, `level` ≤ 1.
- **Fill then drain.** `out_ready`=0 for 16 beats → `level`=16, `overflow`=0. A 17th beat → dropped, `overflow`=1, `err_cnt`=1 (macro on). Drain → 16 beats emitted in order, values 0..15.
- **Simultaneous push/pop at full.** `level`=16, `in_valid`=1, `out_ready`=1 → no drop, `level` stays 16, beat accepted.
- **Framing through a drop.** Drop beat 3 of a tile → next `out_last` is still on the kernel's beat 7; the tile delivers 7 beats.
- **Reset mid-stream.** `level`=5, then assert `reset` → all outputs 0 immediately. After release, the first beat is row 0.
- **Clear race.** `ovf_clr` in the same cycle as a drop → `overflow`=1, `err_cnt`=1.
